mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 The block SHALL have parameter ITER, default 32, meaning iteration cycles per multiply/divide (equal to XLEN).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: SrcA  input  XLEN  operand A (rs1 value).
REQ-006 Port: SrcB  input  XLEN  operand B (ALU source-B mux output).
REQ-007 Port: MDOp  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port: Start  input  1  request; sampled only in IDLE.
REQ-009 Port: Kill  input  1  abort in-flight operation.
REQ-010 Port: Busy  output  1  high while in CALC.
REQ-011 Port: Done  output  1  one-cycle completion pulse.
REQ-012 Port: MDResult  output  XLEN  result, valid from Done, held until next accepted Start.

Function
REQ-013 States SHALL be IDLE, CALC, DONE; Busy = (state==CALC); Done = (state==DONE).
REQ-014 In IDLE with Start=1 at edge N, SrcA, SrcB, MDOp SHALL be latched; operands are not required stable afterwards.
REQ-015 Normal operations SHALL enter CALC at edge N, run exactly ITER iterations, enter DONE at edge N+ITER, Done high for the cycle after edge N+ITER (32 for default).
REQ-016 DONE SHALL return to IDLE at the next edge unconditionally; Start in DONE or CALC SHALL be ignored (no queueing).
REQ-017 Multiply SHALL be shift-add on absolute values with final sign correction; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-018 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes; quotient sign = sign(A) xor sign(B), remainder sign = sign(A) (signed ops only).
REQ-019 Divide by zero (SrcB=0) SHALL bypass CALC: IDLE->DONE at edge N, Done after edge N; DIV/DIVU result all-ones, REM/REMU result = SrcA.
REQ-020 Signed overflow (DIV/REM, SrcA=0x80000000, SrcB=0xFFFFFFFF) SHALL bypass CALC likewise; DIV result 0x80000000, REM result 0.
REQ-021 Kill=1 in CALC SHALL force IDLE at the next edge with no Done pulse and MDResult unchanged; Kill in IDLE/DONE SHALL have no effect; Kill and Start together in IDLE: Kill wins, Start dropped.
REQ-022 Iteration counter SHALL count 0..ITER-1 and not wrap; terminal count drives CALC->DONE.
REQ-023 MDResult SHALL update only on the edge entering DONE.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, Busy 0, Done 0, MDResult 0, all datapath registers 0.
REQ-025 Reset asserted mid-CALC SHALL abandon the operation with no Done; first Start after deassertion SHALL be accepted normally.

Structure
REQ-026 Shared package md_pkg SHALL hold MDOp encodings, state enum, and default XLEN/ITER constants.
REQ-027 One sub-module md_addsub SHALL implement the XLEN+1-bit add/subtract used by both shift-add and restoring-divide steps; control FSM stays in mul_div_unit.

Verification
REQ-028 MUL 7 x -3 (0x00000007, 0xFFFFFFFD): Start at edge N -> Done after edge N+32, MDResult 0xFFFFFFEB.
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> MDResult 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-031 DIVU 5/0 -> Done one cycle after Start, MDResult 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> Done one cycle after Start, MDResult 0.
REQ-032 Kill at iteration 10 -> no Done, Busy low next cycle, MDResult retains prior value; second Start during CALC ignored.
REQ-033 rst_n low at iteration 20 -> all outputs 0 immediately; Start after release completes with correct result in 32 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// control states and default widths.
package md_pkg;

   localparam int XLEN_DEF = 32;
   localparam int ITER_DEF = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op_is_rem(input md_op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic op_a_signed(input md_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_b_signed(input md_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/md_addsub.sv
// Shared adder/subtractor: one shift-add multiply step or one restoring
// divide trial subtraction per cycle.
module md_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: one product or quotient bit per
// cycle on operand magnitudes, sign fix-up on the edge that enters DONE.
module mul_div_unit
   import md_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int ITER = ITER_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [2:0]      MDOp,
   input  logic            Start,
   input  logic            Kill,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] MDResult
);

   localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q;
   md_op_e          op_q;
   logic [XLEN-1:0] hi_q, lo_q, opnd_q, res_q;
   logic            neg_q, rneg_q;

   // ---------------- operand decode at Start ----------------
   md_op_e          op_in;
   logic            a_neg_in, b_neg_in;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, bypass;
   logic [XLEN-1:0] byp_res;

   assign op_in    = md_op_e'(MDOp);
   assign a_neg_in = op_a_signed(op_in) & SrcA[XLEN-1];
   assign b_neg_in = op_b_signed(op_in) & SrcB[XLEN-1];
   assign a_mag    = a_neg_in ? -SrcA : SrcA;
   assign b_mag    = b_neg_in ? -SrcB : SrcB;

   assign div_zero = op_is_div(op_in) && (SrcB == '0);
   assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                     (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
   assign bypass   = div_zero | div_ovf;

   // Divide-by-zero and signed overflow have fixed answers, no iteration needed
   always_comb begin
      byp_res = '0;
      if (div_zero) byp_res = op_is_rem(op_in) ? SrcA : '1;
      else          byp_res = op_is_rem(op_in) ? '0   : SrcA;
   end

   // ---------------- one iteration step ----------------
   logic            is_div;
   logic [XLEN:0]   add_a, add_b, add_y;
   logic [XLEN-1:0] hi_nxt, lo_nxt;

   assign is_div = op_is_div(op_q);

   always_comb begin
      if (is_div) begin
         add_a = {hi_q, lo_q[XLEN-1]};
         add_b = {1'b0, opnd_q};
      end else begin
         add_a = {1'b0, hi_q};
         add_b = lo_q[0] ? {1'b0, opnd_q} : '0;
      end
   end

   md_addsub #(.W(XLEN + 1)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (is_div),
      .y   (add_y)
   );

   // Divide: a set top bit of the trial difference means it went negative, so restore
   always_comb begin
      if (is_div) begin
         hi_nxt = add_y[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : add_y[XLEN-1:0];
         lo_nxt = {lo_q[XLEN-2:0], ~add_y[XLEN]};
      end else begin
         hi_nxt = add_y[XLEN:1];
         lo_nxt = {add_y[0], lo_q[XLEN-1:1]};
      end
   end

   // ---------------- final sign correction ----------------
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quot, remd, calc_res;

   assign prod   = {hi_nxt, lo_nxt};
   assign prod_s = neg_q  ? -prod   : prod;
   assign quot   = neg_q  ? -lo_nxt : lo_nxt;
   assign remd   = rneg_q ? -hi_nxt : hi_nxt;

   always_comb begin
      calc_res = '0;
      unique case (op_q)
         OP_MUL:                       calc_res = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              calc_res = quot;
         OP_REM, OP_REMU:              calc_res = remd;
         default:                      calc_res = '0;
      endcase
   end

   // ---------------- control FSM ----------------
   logic load, step, res_byp_ld, res_calc_ld;

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      step        = 1'b0;
      res_byp_ld  = 1'b0;
      res_calc_ld = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start && !Kill) begin
               if (bypass) begin
                  state_d    = ST_DONE;
                  res_byp_ld = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  load    = 1'b1;
               end
            end
         end
         ST_CALC: begin
            if (Kill) begin
               state_d = ST_IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == LAST) begin
                  state_d     = ST_DONE;
                  res_calc_ld = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != ST_CALC) cnt_q <= '0;
         else if (step)          cnt_q <= cnt_q + 1'b1;
      end
   end

   // NOTE: datapath registers are reset too, so an abandoned operation leaves no stale state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_MUL;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         res_q  <= '0;
      end else begin
         if (load) begin
            op_q   <= op_in;
            neg_q  <= a_neg_in ^ b_neg_in;
            rneg_q <= a_neg_in;
            hi_q   <= '0;
            lo_q   <= op_is_div(op_in) ? a_mag : b_mag;
            opnd_q <= op_is_div(op_in) ? b_mag : a_mag;
         end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
         end
         if (res_byp_ld)       res_q <= byp_res;
         else if (res_calc_ld) res_q <= calc_res;
      end
   end

   assign Busy     = (state_q == ST_CALC);
   assign Done     = (state_q == ST_DONE);
   assign MDResult = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, bypass cases, kill and reset.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] SrcA, SrcB;
   logic [2:0]  MDOp;
   logic        Start, Kill;
   logic        Busy, Done;
   logic [31:0] MDResult;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   mul_div_unit #(.XLEN(32), .ITER(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SrcA     (SrcA),
      .SrcB     (SrcB),
      .MDOp     (MDOp),
      .Start    (Start),
      .Kill     (Kill),
      .Busy     (Busy),
      .Done     (Done),
      .MDResult (MDResult)
   );

   always #5 clk = ~clk;

   // Launch one operation, scramble the operands afterwards, wait (bounded) for Done.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
      @(negedge clk);
      SrcA = a; SrcB = b; MDOp = op; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDOp = 3'($urandom_range(0, 7));
      cyc = 0;
      while (Done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Start = 1'b0; Kill = 1'b0; SrcA = '0; SrcB = '0; MDOp = '0;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if ({Busy, Done, MDResult} !== 34'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got busy=%b done=%b res=%h expected 0 0 0", Busy, Done, MDResult);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      vec_t v[5];
      int   cyc;
      v[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
      v[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
      v[2] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
      v[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
      v[4] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32};
      for (int i = 0; i < 5; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, cyc);
         vec_cnt++;
         if (cyc !== v[i].lat) begin
            err_cnt++;
            $display("FAIL mul_latency[%0d]: got %0d cycles expected %0d", i, cyc, v[i].lat);
         end
         vec_cnt++;
         if (MDResult !== v[i].exp) begin
            err_cnt++;
            $display("FAIL mul_result[%0d]: got %h expected %h", i, MDResult, v[i].exp);
         end
      end
   endtask

   task automatic test_div();
      vec_t v[6];
      int   cyc;
      v[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
      v[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
      v[2] = '{3'd5, 32'd100,       32'd7,         32'd14,        32};
      v[3] = '{3'd7, 32'd100,       32'd7,         32'd2,         32};
      v[4] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32};
      v[5] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32};
      for (int i = 0; i < 6; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, cyc);
         vec_cnt++;
         if (cyc !== v[i].lat) begin
            err_cnt++;
            $display("FAIL div_latency[%0d]: got %0d cycles expected %0d", i, cyc, v[i].lat);
         end
         vec_cnt++;
         if (MDResult !== v[i].exp) begin
            err_cnt++;
            $display("FAIL div_result[%0d]: got %h expected %h", i, MDResult, v[i].exp);
         end
      end
   endtask

   task automatic test_div_special();
      vec_t v[4];
      int   cyc;
      v[0] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};
      v[1] = '{3'd7, 32'd5,         32'd0,         32'd5,         0};
      v[2] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
      v[3] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
      for (int i = 0; i < 4; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, cyc);
         vec_cnt++;
         if (cyc !== v[i].lat) begin
            err_cnt++;
            $display("FAIL special_latency[%0d]: got %0d cycles expected %0d", i, cyc, v[i].lat);
         end
         vec_cnt++;
         if (MDResult !== v[i].exp) begin
            err_cnt++;
            $display("FAIL special_result[%0d]: got %h expected %h", i, MDResult, v[i].exp);
         end
         @(negedge clk);
         vec_cnt++;
         if (Done !== 1'b0 || MDResult !== v[i].exp) begin
            err_cnt++;
            $display("FAIL special_pulse[%0d]: got done=%b res=%h expected 0 %h", i, Done, MDResult, v[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic seen;
      @(negedge clk);
      SrcA = 32'd100; SrcB = 32'd7; MDOp = 3'd5; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (5) @(negedge clk);
      SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; MDOp = 3'd0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      cyc = 6;
      while (Done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      vec_cnt++;
      if (cyc !== 32) begin
         err_cnt++;
         $display("FAIL ignored_start_latency: got %0d cycles expected 32", cyc);
      end
      vec_cnt++;
      if (MDResult !== 32'd14) begin
         err_cnt++;
         $display("FAIL ignored_start_result: got %h expected %h", MDResult, 32'd14);
      end
      seen = 1'b0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
      end
      vec_cnt++;
      if (seen !== 1'b0) begin
         err_cnt++;
         $display("FAIL ignored_start_queued: got activity=%b expected 0", seen);
      end
   endtask

   task automatic test_kill();
      int   cyc;
      logic seen;
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, cyc);
      vec_cnt++;
      if (MDResult !== 32'hFFFF_FFEB) begin
         err_cnt++;
         $display("FAIL kill_prior: got %h expected %h", MDResult, 32'hFFFF_FFEB);
      end
      @(negedge clk);
      SrcA = 32'd100; SrcB = 32'd7; MDOp = 3'd5; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (10) @(negedge clk);
      Kill = 1'b1;
      @(negedge clk);
      Kill = 1'b0;
      vec_cnt++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         err_cnt++;
         $display("FAIL kill_state: got busy=%b done=%b expected 0 0", Busy, Done);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Done === 1'b1) seen = 1'b1;
      end
      vec_cnt++;
      if (seen !== 1'b0 || MDResult !== 32'hFFFF_FFEB) begin
         err_cnt++;
         $display("FAIL kill_no_done: got done_seen=%b res=%h expected 0 %h", seen, MDResult, 32'hFFFF_FFEB);
      end
      // Kill with Start in IDLE: a divide-by-zero would show Done at once if accepted
      SrcA = 32'd5; SrcB = 32'd0; MDOp = 3'd5; Start = 1'b1; Kill = 1'b1;
      @(negedge clk);
      Start = 1'b0; Kill = 1'b0;
      vec_cnt++;
      if (Busy !== 1'b0 || Done !== 1'b0 || MDResult !== 32'hFFFF_FFEB) begin
         err_cnt++;
         $display("FAIL kill_start_idle: got busy=%b done=%b res=%h expected 0 0 %h",
                  Busy, Done, MDResult, 32'hFFFF_FFEB);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      SrcA = 32'h1234_5678; SrcB = 32'd3; MDOp = 3'd0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({Busy, Done, MDResult} !== 34'd0) begin
         err_cnt++;
         $display("FAIL reset_mid: got busy=%b done=%b res=%h expected 0 0 0", Busy, Done, MDResult);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, cyc);
      vec_cnt++;
      if (cyc !== 32 || MDResult !== 32'hFFFF_FFEB) begin
         err_cnt++;
         $display("FAIL reset_restart: got %0d cycles res=%h expected 32 %h", cyc, MDResult, 32'hFFFF_FFEB);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_special();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
